// File: rtl/tape_player_if.sv
// Host-side bundle for tape_player: image download port, transport controls
// and the playback outputs.
interface tape_player_if #(
    parameter int AW = 15
);
    logic          ioctl_download;
    logic          ioctl_wr;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic          play;
    logic          motor;
    logic          ear;
    logic          busy;
    logic          done;
    logic [AW-1:0] pos;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, play, motor,
        input  ear, busy, done, pos
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, play, motor,
        output ear, busy, done, pos
    );
endinterface

// File: rtl/tape_player.sv
// Cassette tape emulator: buffers a downloaded image and replays it as a
// leader / sync / data / gap pulse stream. Optional: TAPE_PLAYER_AUTOSTART_EN.
module tape_player #(
    parameter int AW     = 15,
    parameter int HALF0  = 8,
    parameter int HALF1  = 16,
    parameter int LEADER = 768,
    parameter int GAP    = 4096
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ce,
    tape_player_if.slave  tape
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEADER, S_SYNC, S_DATA, S_GAP, S_DONE
    } state_t;

    localparam int CMAX = (GAP > HALF1) ? GAP : HALF1;
    localparam int CW   = $clog2(CMAX) + 1;
    localparam int BMAX = (LEADER > 8) ? LEADER : 8;
    localparam int BW   = $clog2(BMAX) + 1;

    state_t        state, state_n;
    logic          ear, ear_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [BW-1:0] bits, bits_n;
    logic [AW-1:0] pos, pos_n;
    logic [7:0]    sr, sr_n;
    logic [AW:0]   length;
    logic          play_q, dl_q;

    logic [7:0]    mem [0:(2**AW)-1];
    logic [7:0]    rd_data;
    logic [AW-1:0] rd_addr;

    logic          wr_ok, dl_rise, play_rise, auto_go, start, abort, busy, tick;
    logic [AW:0]   wr_len;
    logic [CW-1:0] half_len;
    logic          half_end, last_byte;

    assign wr_ok     = tape.ioctl_download & tape.ioctl_wr & (tape.ioctl_addr[24:AW] == '0);
    assign wr_len    = {1'b0, tape.ioctl_addr[AW-1:0]} + (AW+1)'(1);
    assign dl_rise   = tape.ioctl_download & ~dl_q;
    assign play_rise = tape.play & ~play_q;
    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign tick      = ce & tape.motor;

`ifdef TAPE_PLAYER_AUTOSTART_EN
    assign auto_go = dl_q & ~tape.ioctl_download & (length != '0);
`else
    assign auto_go = 1'b0;
`endif

    assign start = (play_rise & (length != '0) & ~tape.ioctl_download) | auto_go;
    assign abort = dl_rise & busy;

    // NOTE: the image buffer has no reset so it maps onto block RAM and
    // survives a reset; only the control state is cleared.
    always_ff @(posedge clock) begin
        if (wr_ok)
            mem[tape.ioctl_addr[AW-1:0]] <= tape.ioctl_dout;
        rd_data <= mem[rd_addr];
    end

    // During DATA keep the following byte on rd_data; during SYNC fetch byte 0.
    assign rd_addr = (state == S_DATA) ? pos + AW'(1) : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            length <= '0;
        end else if (dl_rise) begin
            length <= wr_ok ? wr_len : '0;
        end else if (wr_ok && (wr_len > length)) begin
            length <= wr_len;
        end
    end

    always_comb begin
        half_len = CW'(HALF0);
        case (state)
            S_SYNC:  half_len = CW'(HALF1);
            S_DATA:  half_len = sr[7] ? CW'(HALF1) : CW'(HALF0);
            default: half_len = CW'(HALF0);
        endcase
    end

    assign half_end  = (cnt == half_len - CW'(1));
    assign last_byte = ({1'b0, pos} == length - (AW+1)'(1));

    // NOTE: every register is assigned with <= so all of them sample the
    // pre-edge values; a blocking assignment here would create ordering races.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            ear    <= 1'b0;
            cnt    <= '0;
            bits   <= '0;
            pos    <= '0;
            sr     <= '0;
            play_q <= 1'b0;
            dl_q   <= 1'b0;
        end else begin
            state  <= state_n;
            ear    <= ear_n;
            cnt    <= cnt_n;
            bits   <= bits_n;
            pos    <= pos_n;
            sr     <= sr_n;
            play_q <= tape.play;
            dl_q   <= tape.ioctl_download;
        end
    end

    // NOTE: every next-state value is defaulted to its current value first,
    // so no path through the case leaves one unassigned (no latches).
    always_comb begin
        state_n = state;
        ear_n   = ear;
        cnt_n   = cnt;
        bits_n  = bits;
        pos_n   = pos;
        sr_n    = sr;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_LEADER;
                    ear_n   = 1'b1;
                    cnt_n   = '0;
                    bits_n  = '0;
                end
            end

            S_LEADER, S_SYNC, S_DATA: begin
                if (tick) begin
                    if (!half_end) begin
                        cnt_n = cnt + CW'(1);
                    end else if (ear) begin
                        ear_n = 1'b0;
                        cnt_n = '0;
                    end else begin
                        // End of a full bit cycle: start the next bit at once.
                        ear_n = 1'b1;
                        cnt_n = '0;
                        if (state == S_LEADER) begin
                            if (bits == BW'(LEADER - 1)) begin
                                state_n = S_SYNC;
                                bits_n  = '0;
                                pos_n   = '0;
                            end else begin
                                bits_n = bits + BW'(1);
                            end
                        end else if (state == S_SYNC) begin
                            state_n = S_DATA;
                            sr_n    = rd_data;
                            bits_n  = '0;
                        end else if (bits == BW'(7)) begin
                            if (last_byte) begin
                                state_n = S_GAP;
                                ear_n   = 1'b0;
                            end else begin
                                pos_n  = pos + AW'(1);
                                sr_n   = rd_data;
                                bits_n = '0;
                            end
                        end else begin
                            sr_n   = {sr[6:0], 1'b0};
                            bits_n = bits + BW'(1);
                        end
                    end
                end
            end

            S_GAP: begin
                if (tick) begin
                    if (cnt == CW'(GAP - 1)) begin
                        state_n = S_DONE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end

            S_DONE: begin
                if (play_rise)
                    state_n = S_IDLE;
            end

            default: state_n = S_IDLE;
        endcase

        if (abort) begin
            state_n = S_IDLE;
            ear_n   = 1'b0;
            cnt_n   = '0;
            bits_n  = '0;
            pos_n   = '0;
        end
    end

    assign tape.ear  = ear;
    assign tape.busy = busy;
    assign tape.done = (state == S_DONE);
    assign tape.pos  = pos;

endmodule

// File: tb/tb_tape_player.sv
// Directed bench for tape_player: pulse timing, multi-byte streaming, pause,
// abort, reset, zero-length play, address limit and autostart.
module tb_tape_player;

    localparam int AW = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ce    = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] img [0:7];
    int         img_n;

    tape_player_if #(.AW(AW)) bus ();

    tape_player #(
        .AW(AW), .HALF0(2), .HALF1(4), .LEADER(3), .GAP(10)
    ) dut (
        .clock (clock),
        .reset (reset),
        .ce    (ce),
        .tape  (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int addr, input logic [7:0] data);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 25'(addr);
        bus.ioctl_dout = data;
        @(negedge clock);
        bus.ioctl_wr   = 1'b0;
    endtask

    task automatic load();
        bus.ioctl_download = 1'b1;
        for (int i = 0; i < img_n; i++) wr(i, img[i]);
        bus.ioctl_download = 1'b0;
    endtask

    task automatic pulse_play();
        bus.play = 1'b1;
        @(negedge clock);
        bus.play = 1'b0;
    endtask

    // Leaves the bench on the first sample after playback has started.
    task automatic kick();
        if (bus.done === 1'b1) begin
            pulse_play();
            check(bus.done, 0, "done_to_idle_done");
            check(bus.busy, 0, "done_to_idle_busy");
            @(negedge clock);
        end
        if (bus.busy !== 1'b1) pulse_play();
    endtask

    task automatic wait_high();
        int c = 0;
        while (bus.ear !== 1'b1 && c < 200) begin
            c++;
            @(negedge clock);
        end
        check(bus.ear, 1, "start_ear_high");
    endtask

    // Counts consecutive samples at level lvl; exits on the first other sample.
    task automatic run(input logic lvl, input int len, input string tag);
        int c = 0;
        while (bus.ear === lvl && c < 200) begin
            c++;
            @(negedge clock);
        end
        check(c, len, tag);
    endtask

    task automatic run_preamble();
        wait_high();
        check(bus.busy, 1, "busy_in_leader");
        for (int i = 0; i < 3; i++) begin
            run(1'b1, 2, "leader_hi");
            run(1'b0, 2, "leader_lo");
        end
        run(1'b1, 4, "sync_hi");
        run(1'b0, 4, "sync_lo");
    endtask

    task automatic wait_done();
        int c = 0;
        while (bus.done !== 1'b1 && c < 2000) begin
            c++;
            @(negedge clock);
        end
        check(bus.done, 1, "reach_done");
    endtask

    task automatic play_check();
        int h = 2;
        int c = 0;
        logic hi_seen = 1'b0;
        run_preamble();
        for (int k = 0; k < img_n; k++) begin
            for (int b = 7; b >= 0; b--) begin
                h = img[k][b] ? 4 : 2;
                if (b == 7) check(32'(bus.pos), k, "pos_at_byte_start");
                run(1'b1, h, "data_hi");
                if (!(k == img_n - 1 && b == 0)) run(1'b0, h, "data_lo");
            end
        end
        // Last bit's low half followed by the gap, then DONE.
        while (bus.done !== 1'b1 && c < 100) begin
            if (bus.ear !== 1'b0) hi_seen = 1'b1;
            c++;
            @(negedge clock);
        end
        check(c, h + 10, "last_low_plus_gap");
        check(hi_seen, 0, "gap_ear_low");
        check(bus.done, 1, "done_after_gap");
        check(bus.busy, 0, "busy_after_gap");
        check(bus.ear, 0, "ear_in_done");
        check(32'(bus.pos), img_n - 1, "pos_held_in_done");
    endtask

    initial begin
        int hi;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        bus.play           = 1'b0;
        bus.motor          = 1'b1;

        // Reset state.
        repeat (3) @(negedge clock);
        check(bus.ear,  0, "rst_ear");
        check(bus.busy, 0, "rst_busy");
        check(bus.done, 0, "rst_done");
        check(32'(bus.pos), 0, "rst_pos");
        reset = 1'b0;
        @(negedge clock);

        // Single byte 0xA5: full leader/sync/data/gap timing.
        img[0] = 8'hA5; img_n = 1;
        load();
        check(32'(dut.length), 1, "len_one_byte");
        kick();
        play_check();

        // Multi-byte stream: contiguous bits across byte boundaries.
        img[0] = 8'h00; img[1] = 8'hFF; img[2] = 8'h3C; img_n = 3;
        load();
        check(32'(dut.length), 3, "len_three_bytes");
        kick();
        play_check();

        // Pause mid high half of the first data bit (0xFF -> H=4).
        img[0] = 8'hFF; img_n = 1;
        load();
        kick();
        run_preamble();
        @(negedge clock);
        check(bus.ear, 1, "pause_pre_ear");
        bus.motor = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            check(bus.ear, 1, "pause_ear_frozen");
        end
        check(32'(bus.pos), 0, "pause_pos_frozen");
        check(bus.busy, 1, "pause_busy");
        bus.motor = 1'b1;
        hi = 52;
        @(negedge clock);
        while (bus.ear === 1'b1 && hi < 200) begin
            hi++;
            @(negedge clock);
        end
        check(hi - 50, 4, "pause_high_total");
        run(1'b0, 4, "pause_low_half");
        wait_done();

        // Abort during LEADER by starting a new download.
        img[0] = 8'h55; img_n = 1;
        load();
        kick();
        wait_high();
        @(negedge clock);
        bus.ioctl_download = 1'b1;
        @(negedge clock);
        check(bus.busy, 0, "abort_busy");
        check(bus.ear,  0, "abort_ear");
        check(bus.done, 0, "abort_done");
        check(32'(bus.pos), 0, "abort_pos");
        check(32'(dut.length), 0, "abort_len_cleared");
        wr(0, 8'h80);
        wr(1, 8'h01);
        wr(16, 8'hEE);
        check(32'(dut.length), 2, "len_ignores_oob");
        bus.ioctl_download = 1'b0;
        img[0] = 8'h80; img[1] = 8'h01; img_n = 2;
        kick();
        play_check();

        // Asynchronous reset in the middle of byte 1.
        img[0] = 8'h00; img[1] = 8'h00; img_n = 2;
        load();
        kick();
        wait_high();
        repeat (60) @(negedge clock);
        check(32'(bus.pos), 1, "pre_reset_pos");
        check(bus.busy, 1, "pre_reset_busy");
        #2 reset = 1'b1;
        #1;
        check(bus.ear,  0, "reset_ear");
        check(bus.busy, 0, "reset_busy");
        check(bus.done, 0, "reset_done");
        check(32'(bus.pos), 0, "reset_pos");
        @(negedge clock);
        reset = 1'b0;
        check(32'(dut.length), 0, "reset_len");

        // Play with an empty image is ignored.
        pulse_play();
        repeat (3) @(negedge clock);
        check(bus.busy, 0, "empty_play_busy");
        check(bus.ear,  0, "empty_play_ear");

        // Download end: autostart only when the option is built in.
        bus.ioctl_download = 1'b1;
        wr(0, 8'h11);
        wr(1, 8'h22);
        wr(2, 8'h33);
        wr(15, 8'h44);
        bus.ioctl_download = 1'b0;
        check(32'(dut.length), 16, "len_saturated");
        @(negedge clock);
`ifdef TAPE_PLAYER_AUTOSTART_EN
        check(bus.busy, 1, "autostart_busy");
`else
        check(bus.busy, 0, "no_autostart_busy");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tape_player.md
TAPE_PLAYER -- requirements
Module: tape_player

Interface
REQ-001 Parameter AW, default 15: tape buffer address width; the buffer holds 2^AW bytes.
REQ-002 Parameter HALF0, default 8: length of one half-cycle of a '0' bit, in ce ticks.
REQ-003 Parameter HALF1, default 16: length of one half-cycle of a '1' bit, in ce ticks.
REQ-004 Parameter LEADER, default 768: number of '0' bit cycles in the leader.
REQ-005 Parameter GAP, default 4096: number of ce ticks of ear low after the last byte.
REQ-006 Ports:
- clock  in  1: single system clock; all logic is on its rising edge.
- reset  in  1: asynchronous, active-high reset.
- ce  in  1: tick enable; all timing counters advance only when ce=1.
- ioctl_download  in  1: high while the host is loading a tape image.
- ioctl_wr  in  1: write strobe for one image byte.
- ioctl_addr  in  25: byte address within the image.
- ioctl_dout  in  8: image byte.
- play  in  1: a rising edge starts playback.
- motor  in  1: cassette motor; 0 pauses playback.
- ear  out  1: tape audio bit, fed to the machine's ear input.
- busy  out  1: high whenever state is not IDLE or DONE.
- done  out  1: high in state DONE.
- pos  out  AW: index of the byte currently being played.

Function
REQ-007 Buffer write: when ioctl_download=1, ioctl_wr=1 and ioctl_addr < 2^AW, the block SHALL write ioctl_dout to buffer[ioctl_addr[AW-1:0]]; writes at higher addresses are dropped.
REQ-008 Image length: on the rising edge of ioctl_download the length SHALL be cleared to 0; each accepted write SHALL set length to max(length, addr+1), saturating at 2^AW.
REQ-009 States: IDLE, LEADER, SYNC, DATA, GAP, DONE.
REQ-010 IDLE->LEADER SHALL occur on a play rising edge when length>0 and ioctl_download=0; a play edge with length=0 SHALL be ignored.
REQ-011 Bit cycle: ear=1 for H ticks, then ear=0 for H ticks; H=HALF0 for a '0', H=HALF1 for a '1'.
- Pause behaviour: ticks counted only when ce=1 and motor=1.
REQ-012 LEADER SHALL emit LEADER '0' bits, then go to SYNC.
REQ-013 SYNC SHALL emit exactly one '1' bit, then go to DATA with pos=0.
REQ-014 DATA SHALL emit buffer[pos] MSB first, 8 bits per byte.
- After bit 0 with pos=length-1: go to GAP.
- Otherwise: pos increments and the next byte starts with no extra ticks.
REQ-015 Byte fetch: the buffer read has 1-clock latency.
- The next byte SHALL be prefetched so that inter-byte bit timing is identical to intra-byte timing.
- Requires HALF0 >= 2.
REQ-016 GAP SHALL hold ear=0 for GAP ticks, then go to DONE.
REQ-017 DONE SHALL hold ear=0 and go to IDLE on the next play rising edge. That edge restarts playback only if REQ-010 holds on a later edge.
REQ-018 ioctl_download rising while busy SHALL force IDLE, ear=0 and pos=0 in the next clock.
REQ-019 motor=0 SHALL freeze state, counters, pos and ear at their current values; resuming continues exactly where playback stopped.
REQ-020 play edge detection SHALL use a registered copy of play; a play edge while busy SHALL be ignored.
REQ-021 pos SHALL hold its last value in GAP, DONE and IDLE until the next start; it resets to 0 only at the entry to SYNC and on abort.

Reset
REQ-022 While reset=1:
- state=IDLE, ear=0, busy=0, done=0, pos=0, length=0.
- All counters are 0 and the registered play is 0.
REQ-023 Buffer contents are not cleared by reset.
REQ-024 Reset asserted mid-playback SHALL abort immediately (asynchronous), with no further ear toggles.

Configuration
REQ-025 Macro TAPE_PLAYER_AUTOSTART_EN:
- Defined: the falling edge of ioctl_download with length>0 SHALL start playback as a play edge would (IDLE->LEADER in the next clock).
- Undefined: playback starts only via play (REQ-010), and download completion leaves state IDLE.

Verification
REQ-026 Timing: HALF0=2, HALF1=4, LEADER=3, GAP=10, ce=1 always; load 1 byte 0xA5; play pulse -> ear high/low runs of 2,2 ×3; then 4,4; then bits 1,0,1,0,0,1,0,1 with half-widths 4,2,4,2,2,4,2,4; then 10 low ticks; done=1, busy=0.
REQ-027 Multi-byte: load 0x00,0xFF,0x3C -> every bit period is contiguous; pos steps 0->1->2; no stretched half-cycle at byte boundaries.
REQ-028 Pause: drop motor for 50 clocks mid-bit in DATA -> ear, pos and tick count are frozen; total high time of that half-cycle is still exactly H.
REQ-029 Abort: raise ioctl_download during LEADER -> next clock state=IDLE, ear=0, busy=0; new length equals the new highest address+1.
REQ-030 Reset and edges: reset pulse during DATA -> all outputs 0 immediately. Play with length=0 -> stays IDLE. Write at addr 2^AW -> ignored and length unchanged.
REQ-031 Autostart: with TAPE_PLAYER_AUTOSTART_EN defined, end of download of 4 bytes -> busy=1 one clock later without play. Without the macro -> busy stays 0.
